// File: rtl/auth_pkg.sv
// Shared types and default command bytes for the rider-authentication controller.
package auth_pkg;

    typedef enum logic [2:0] {
        S_OFF,
        S_PIN,
        S_PWR_LINK,
        S_PWR_GRACE,
        S_LOCK
    } state_t;

    localparam logic [7:0] GO_BYTE_DEF   = 8'h67;
    localparam logic [7:0] STOP_BYTE_DEF = 8'h73;

endpackage

// File: rtl/UART_rx.sv
// 8N1 UART receiver: rx_rdy rises one clock after the stop-bit sample and holds until clr_rdy.
// BAUD_DIV is clocks per bit; a start bit that is high again at mid-bit is discarded as a glitch.
module UART_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rx_rdy
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          r_busy;
    logic          r_rdy;
    logic [CW-1:0] r_baud_cnt;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_data;
    logic          w_tick;

    assign w_tick  = r_busy && (r_baud_cnt == '0);
    assign rx_data = r_data;
    assign rx_rdy  = r_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Bit 0 is the start-bit check, bits 1..8 are data (LSB first), bit 9 is stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_data     <= '0;
        end else if (!r_busy) begin
            if (!r_rx_sync) begin
                r_busy     <= 1'b1;
                r_baud_cnt <= CW'(BAUD_DIV / 2);
                r_bit_cnt  <= '0;
            end
        end else if (!w_tick) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
        end else begin
            r_baud_cnt <= CW'(BAUD_DIV - 1);
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if ((r_bit_cnt == 4'd0) && r_rx_sync) begin
                r_busy <= 1'b0;
            end else if (r_bit_cnt == 4'd9) begin
                r_busy <= 1'b0;
            end else if (r_bit_cnt != 4'd0) begin
                r_data <= {r_rx_sync, r_data[7:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy <= 1'b0;
        end else if (w_tick && (r_bit_cnt == 4'd9) && r_rx_sync) begin
            r_rdy <= 1'b1;
        end else if (clr_rdy) begin
            r_rdy <= 1'b0;
        end
    end

endmodule

// File: rtl/auth_ctrl.sv
// Rider auth / power-enable FSM fed by UART bytes; outputs register next-state (1 clk after rx_rdy).
// Every byte is consumed immediately; AUTH_PIN_EN adds PIN check, fail count and lockout.
module auth_ctrl
    import auth_pkg::*;
#(
    parameter logic [7:0]           GO_BYTE     = GO_BYTE_DEF,
    parameter logic [7:0]           STOP_BYTE   = STOP_BYTE_DEF,
    parameter int                   PIN_LEN     = 2,
    parameter logic [8*PIN_LEN-1:0] PIN         = 16'hA55A,
    parameter int                   MAX_FAIL    = 3,
    parameter int                   HB_TIMEOUT  = 50_000_000,
    parameter int                   OFF_GRACE   = 25_000_000,
    parameter int                   LOCK_CYCLES = 500_000_000,
    parameter int                   BAUD_DIV    = 2604
) (
    input  logic clk,
    input  logic rst_n,
    input  logic RX,
    input  logic rider_off,
    output logic pwr_up,
    output logic link_up,
    output logic locked,
    output logic auth_fail
);

    localparam int HBW = $clog2(HB_TIMEOUT + 1);
    localparam int GW  = $clog2(OFF_GRACE + 1);

    logic [7:0]     w_rx_data;
    logic           w_rx_rdy;
    logic           w_clr_rdy;
    state_t         r_state;
    state_t         w_state_nxt;
    logic [HBW-1:0] r_hb_cnt;
    logic [GW-1:0]  r_grace_cnt;
    logic           w_hb_live;
    logic           w_hb_exp;
    logic           w_grace_done;
    logic           w_is_go;
    logic           w_is_stop;
    logic           w_pwr_nxt;
    logic           w_link_nxt;
    logic           r_pwr_up;
    logic           r_link_up;

    UART_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (w_clr_rdy),
        .rx_data (w_rx_data),
        .rx_rdy  (w_rx_rdy)
    );

    assign w_clr_rdy    = w_rx_rdy;
    assign w_is_go      = w_rx_rdy && (w_rx_data == GO_BYTE);
    assign w_is_stop    = w_rx_rdy && (w_rx_data == STOP_BYTE);
    assign w_hb_live    = (r_state == S_PIN) || (r_state == S_PWR_LINK);
    // A byte arriving in the expiry cycle wins, so expiry is masked by rx_rdy.
    assign w_hb_exp     = !w_rx_rdy && (r_hb_cnt == HBW'(HB_TIMEOUT - 1));
    assign w_grace_done = rider_off && (r_grace_cnt == GW'(OFF_GRACE - 1));

`ifdef AUTH_PIN_EN
    localparam int IW = (PIN_LEN > 1) ? $clog2(PIN_LEN) : 1;
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;
    logic [FW-1:0] r_fail_cnt;
    logic [FW-1:0] w_fail_nxt;
    logic [LW-1:0] r_lock_cnt;
    logic [7:0]    w_pin_byte;
    logic          w_lock_done;
    logic          w_bad_pin;
    logic          w_lock_nxt;
    logic          r_locked;
    logic          r_auth_fail;

    // First PIN byte received is the most significant byte of PIN.
    assign w_pin_byte  = PIN[8*(PIN_LEN-1-int'(r_idx)) +: 8];
    assign w_lock_done = (r_lock_cnt == LW'(LOCK_CYCLES - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_OFF;
            r_pwr_up  <= 1'b0;
            r_link_up <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pwr_up  <= w_pwr_nxt;
            r_link_up <= w_link_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
`ifdef AUTH_PIN_EN
        w_idx_nxt   = r_idx;
        w_fail_nxt  = r_fail_cnt;
        w_bad_pin   = 1'b0;
`endif
        case (r_state)
            S_OFF: begin
                if (w_is_go) begin
`ifdef AUTH_PIN_EN
                    w_state_nxt = S_PIN;
                    w_idx_nxt   = '0;
`else
                    w_state_nxt = S_PWR_LINK;
`endif
                end
            end
`ifdef AUTH_PIN_EN
            S_PIN: begin
                if (w_rx_rdy) begin
                    if (w_rx_data != w_pin_byte) begin
                        w_bad_pin = 1'b1;
                        if (r_fail_cnt != FW'(MAX_FAIL)) begin
                            w_fail_nxt = r_fail_cnt + 1'b1;
                        end
                        w_state_nxt = (w_fail_nxt == FW'(MAX_FAIL)) ? S_LOCK : S_OFF;
                    end else if (r_idx == IW'(PIN_LEN - 1)) begin
                        w_state_nxt = S_PWR_LINK;
                        w_fail_nxt  = '0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else if (w_hb_exp) begin
                    w_state_nxt = S_OFF;
                end
            end
            S_LOCK: begin
                if (w_lock_done) begin
                    w_state_nxt = S_OFF;
                    w_fail_nxt  = '0;
                end
            end
`endif
            S_PWR_LINK: begin
                if (w_is_stop || w_hb_exp) begin
                    w_state_nxt = rider_off ? S_OFF : S_PWR_GRACE;
                end
            end
            S_PWR_GRACE: begin
                if (w_is_go) begin
                    w_state_nxt = S_PWR_LINK;
                end else if (w_grace_done) begin
                    w_state_nxt = S_OFF;
                end
            end
            default: w_state_nxt = S_OFF;
        endcase
    end

    always_comb begin
        w_pwr_nxt  = (w_state_nxt == S_PWR_LINK) || (w_state_nxt == S_PWR_GRACE);
        w_link_nxt = (w_state_nxt == S_PWR_LINK);
`ifdef AUTH_PIN_EN
        w_lock_nxt = (w_state_nxt == S_LOCK);
`endif
    end

    // Heartbeat restarts on any byte and on entry into PIN/PWR_LINK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hb_cnt    <= '0;
            r_grace_cnt <= '0;
        end else begin
            if (w_rx_rdy || !w_hb_live || (w_state_nxt != r_state)) begin
                r_hb_cnt <= '0;
            end else begin
                r_hb_cnt <= r_hb_cnt + 1'b1;
            end
            if ((r_state == S_PWR_GRACE) && rider_off && (w_state_nxt == S_PWR_GRACE)) begin
                r_grace_cnt <= r_grace_cnt + 1'b1;
            end else begin
                r_grace_cnt <= '0;
            end
        end
    end

`ifdef AUTH_PIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_fail_cnt  <= '0;
            r_lock_cnt  <= '0;
            r_locked    <= 1'b0;
            r_auth_fail <= 1'b0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_fail_cnt  <= w_fail_nxt;
            r_lock_cnt  <= ((r_state == S_LOCK) && (w_state_nxt == S_LOCK)) ? r_lock_cnt + 1'b1 : '0;
            r_locked    <= w_lock_nxt;
            r_auth_fail <= w_bad_pin;
        end
    end

    assign locked    = r_locked;
    assign auth_fail = r_auth_fail;
`else
    assign locked    = 1'b0;
    assign auth_fail = 1'b0;
`endif

    assign pwr_up  = r_pwr_up;
    assign link_up = r_link_up;

endmodule

// File: tb/tb_auth_ctrl.sv
// Directed bench for auth_ctrl: UART byte stimulus, per-scenario inline checks against hand-derived values.
module tb_auth_ctrl;

    localparam int BAUD = 16;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic RX        = 1'b1;
    logic rider_off = 1'b0;
    logic pwr_up;
    logic link_up;
    logic locked;
    logic auth_fail;

    int   total       = 0;
    int   bad         = 0;
    int   cyc         = 0;
    int   fail_pulses = 0;
    int   lock_rise   = -1;
    int   lock_fall   = -1;
    logic prev_locked = 1'b0;
    logic ever_locked = 1'b0;
    logic ever_fail   = 1'b0;

    auth_ctrl #(
        .PIN_LEN     (2),
        .PIN         (16'hA55A),
        .MAX_FAIL    (3),
        .HB_TIMEOUT  (1000),
        .OFF_GRACE   (200),
        .LOCK_CYCLES (500),
        .BAUD_DIV    (BAUD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .rider_off (rider_off),
        .pwr_up    (pwr_up),
        .link_up   (link_up),
        .locked    (locked),
        .auth_fail (auth_fail)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (auth_fail === 1'b1) begin
            fail_pulses = fail_pulses + 1;
            ever_fail   = 1'b1;
        end
        if (locked === 1'b1) ever_locked = 1'b1;
        if ((locked === 1'b1) && (prev_locked !== 1'b1)) lock_rise = cyc;
        if ((locked !== 1'b1) && (prev_locked === 1'b1)) lock_fall = cyc;
        prev_locked = locked;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tx_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            RX = frame[i];
            repeat (BAUD) @(posedge clk);
            #1;
        end
    endtask

    task automatic authenticate;
`ifdef AUTH_PIN_EN
        tx_byte(8'h67);
        tx_byte(8'hA5);
        tx_byte(8'h5A);
`else
        tx_byte(8'h67);
`endif
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (pwr_up !== 1'b0)    begin bad++; $display("FAIL reset_pwr_up: got %b want 0", pwr_up); end
        total++; if (link_up !== 1'b0)   begin bad++; $display("FAIL reset_link_up: got %b want 0", link_up); end
        total++; if (locked !== 1'b0)    begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        total++; if (auth_fail !== 1'b0) begin bad++; $display("FAIL reset_auth_fail: got %b want 0", auth_fail); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_power_up;
        bit seen;
        rider_off = 1'b0;
`ifdef AUTH_PIN_EN
        tx_byte(8'h67);
        tx_byte(8'hA5);
`endif
        fork
`ifdef AUTH_PIN_EN
            tx_byte(8'h5A);
`else
            tx_byte(8'h67);
`endif
            begin
                seen = 1'b0;
                for (int i = 0; (i < 400) && !seen; i++) begin
                    @(negedge clk);
                    if (dut.w_rx_rdy === 1'b1) seen = 1'b1;
                end
                total++;
                if (!seen) begin
                    bad++; $display("FAIL up_rx_rdy: no byte strobe within 400 cycles");
                end else begin
                    total++; if (pwr_up !== 1'b0) begin bad++; $display("FAIL up_early: pwr_up=%b in strobe cycle, want 0", pwr_up); end
                    @(negedge clk);
                    total++; if (pwr_up !== 1'b1)  begin bad++; $display("FAIL up_pwr: pwr_up=%b one cycle after strobe, want 1", pwr_up); end
                    total++; if (link_up !== 1'b1) begin bad++; $display("FAIL up_link: link_up=%b one cycle after strobe, want 1", link_up); end
                end
            end
        join
        rider_off = 1'b1;
        tx_byte(8'h73);
        repeat (2) @(negedge clk);
        total++; if (pwr_up !== 1'b0)  begin bad++; $display("FAIL stop_off_pwr: got %b want 0", pwr_up); end
        total++; if (link_up !== 1'b0) begin bad++; $display("FAIL stop_off_link: got %b want 0", link_up); end
        rider_off = 1'b0;
    endtask

    task automatic test_grace;
        rider_off = 1'b0;
        authenticate();
        tx_byte(8'h73);
        repeat (2) @(negedge clk);
        total++; if (pwr_up !== 1'b1)  begin bad++; $display("FAIL grace_pwr: got %b want 1", pwr_up); end
        total++; if (link_up !== 1'b0) begin bad++; $display("FAIL grace_link: got %b want 0", link_up); end
        @(posedge clk); #1;
        rider_off = 1'b1;
        repeat (150) @(posedge clk);
        #1;
        rider_off = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (pwr_up !== 1'b1) begin bad++; $display("FAIL grace_pulse: pwr_up=%b after short rider_off, want 1", pwr_up); end
        rider_off = 1'b1;
        repeat (199) @(posedge clk);
        #1;
        total++; if (pwr_up !== 1'b1) begin bad++; $display("FAIL grace_199: pwr_up=%b at 199 cycles, want 1", pwr_up); end
        @(posedge clk);
        #1;
        total++; if (pwr_up !== 1'b0) begin bad++; $display("FAIL grace_200: pwr_up=%b at 200 cycles, want 0", pwr_up); end
        rider_off = 1'b0;
    endtask

    task automatic test_hb_loss;
        rider_off = 1'b0;
        authenticate();
        repeat (990) @(negedge clk);
        total++; if (link_up !== 1'b1) begin bad++; $display("FAIL hb_early: link_up=%b before timeout, want 1", link_up); end
        repeat (20) @(negedge clk);
        total++; if (link_up !== 1'b0) begin bad++; $display("FAIL hb_link: link_up=%b after timeout, want 0", link_up); end
        total++; if (pwr_up !== 1'b1)  begin bad++; $display("FAIL hb_pwr: pwr_up=%b after timeout, want 1", pwr_up); end
        tx_byte(8'h67);
        repeat (2) @(negedge clk);
        total++; if (link_up !== 1'b1) begin bad++; $display("FAIL hb_relink: link_up=%b after GO, want 1", link_up); end
        rider_off = 1'b1;
        tx_byte(8'h73);
        repeat (2) @(negedge clk);
        total++; if (pwr_up !== 1'b0) begin bad++; $display("FAIL hb_stop: pwr_up=%b, want 0", pwr_up); end
        rider_off = 1'b0;
    endtask

`ifdef AUTH_PIN_EN
    task automatic test_lockout;
        rider_off   = 1'b0;
        fail_pulses = 0;
        for (int a = 0; a < 3; a++) begin
            tx_byte(8'h67);
            tx_byte(8'hA5);
            tx_byte(8'h00);
            repeat (2) @(negedge clk);
            total++; if (fail_pulses !== a + 1) begin bad++; $display("FAIL lock_pulse%0d: pulses=%0d want %0d", a, fail_pulses, a + 1); end
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_set: locked=%b want 1", locked); end
        authenticate();
        total++; if (pwr_up !== 1'b0)   begin bad++; $display("FAIL lock_ignore_pwr: pwr_up=%b want 0", pwr_up); end
        total++; if (locked !== 1'b1)   begin bad++; $display("FAIL lock_hold: locked=%b want 1", locked); end
        total++; if (fail_pulses !== 3) begin bad++; $display("FAIL lock_no_pulse: pulses=%0d want 3", fail_pulses); end
        for (int i = 0; (i < 600) && (locked === 1'b1); i++) @(negedge clk);
        @(negedge clk);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_release: locked=%b want 0", locked); end
        total++; if (lock_fall - lock_rise !== 500) begin bad++; $display("FAIL lock_len: %0d cycles want 500", lock_fall - lock_rise); end
        authenticate();
        repeat (2) @(negedge clk);
        total++; if (pwr_up !== 1'b1) begin bad++; $display("FAIL lock_reauth: pwr_up=%b want 1", pwr_up); end
        rider_off = 1'b1;
        tx_byte(8'h73);
        rider_off = 1'b0;
    endtask

    task automatic test_pin_timeout;
        int p0;
        p0 = fail_pulses;
        tx_byte(8'h67);
        tx_byte(8'hA5);
        repeat (1100) @(negedge clk);
        tx_byte(8'h5A);
        repeat (2) @(negedge clk);
        total++; if (pwr_up !== 1'b0)    begin bad++; $display("FAIL pin_to_pwr: pwr_up=%b want 0", pwr_up); end
        total++; if (fail_pulses !== p0) begin bad++; $display("FAIL pin_to_fail: pulses=%0d want %0d", fail_pulses, p0); end
    endtask
`endif

    task automatic test_reset_mid;
        rider_off = 1'b0;
        authenticate();
        repeat (2) @(negedge clk);
        total++; if (pwr_up !== 1'b1) begin bad++; $display("FAIL rst_pre: pwr_up=%b want 1", pwr_up); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (pwr_up !== 1'b0)  begin bad++; $display("FAIL rst_async_pwr: pwr_up=%b want 0", pwr_up); end
        total++; if (link_up !== 1'b0) begin bad++; $display("FAIL rst_async_link: link_up=%b want 0", link_up); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_grace();
        test_hb_loss();
`ifdef AUTH_PIN_EN
        test_lockout();
        test_pin_timeout();
`endif
        test_reset_mid();
`ifndef AUTH_PIN_EN
        total++; if (ever_locked !== 1'b0) begin bad++; $display("FAIL nopin_locked: locked seen %b want 0", ever_locked); end
        total++; if (ever_fail !== 1'b0)   begin bad++; $display("FAIL nopin_auth_fail: pulse seen %b want 0", ever_fail); end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/auth_ctrl.md
# auth_ctrl

Parametrised rider-authentication and power-enable controller: receives command bytes from the BLE module over UART, requires a GO byte followed by a PIN sequence, then holds `pwr_up` while the link is alive or the rider remains aboard. It adds heartbeat-loss detection, a rider-off grace filter and a bad-PIN lockout. It sits between the BLE UART pin and the power/balance control path.

## Interface
- GO_BYTE, 8'h67, command that starts authentication / re-attaches link
- STOP_BYTE, 8'h73, command that ends the link session
- PIN_LEN, 2, number of PIN bytes following GO (1..8)
- PIN, 16'hA55A, expected PIN, width 8*PIN_LEN, first byte received = MSB
- MAX_FAIL, 3, consecutive bad PINs before lockout (>=1)
- HB_TIMEOUT, 50_000_000, cycles without any received byte before the link is declared lost
- OFF_GRACE, 25_000_000, consecutive `rider_off` cycles required to power down when unlinked
- LOCK_CYCLES, 500_000_000, lockout duration in cycles
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- RX  input  1  UART serial line from BLE module
- rider_off  input  1  high when no rider is detected on the platform
- pwr_up  output  1  power enable, registered
- link_up  output  1  high in PWR_LINK, registered
- locked  output  1  high in LOCK, registered
- auth_fail  output  1  one-cycle pulse per rejected PIN, registered

## Operation
- Every byte is consumed: `clr_rdy` to the receiver is asserted in each cycle `rx_rdy` is high, in all states.
- States: OFF, PIN, PWR_LINK, PWR_GRACE, LOCK. Reset to OFF; all outputs 0; fail count 0; timers 0.
- OFF: byte == GO_BYTE -> PIN, byte index 0. Other bytes ignored.
- PIN: each byte is compared against PIN byte `idx`. On mismatch: `auth_fail` pulse; fail count +1; if count reaches MAX_FAIL -> LOCK, else -> OFF. On match at `idx == PIN_LEN-1` -> PWR_LINK, fail count cleared. Otherwise `idx` +1. HB_TIMEOUT with no byte -> OFF, no fail counted.
- PWR_LINK: byte == STOP_BYTE, or heartbeat expiry -> OFF if `rider_off`, else PWR_GRACE. Any other byte restarts the heartbeat timer.
- PWR_GRACE: byte == GO_BYTE -> PWR_LINK, no PIN required. `rider_off` high for OFF_GRACE consecutive cycles -> OFF. The grace counter clears whenever `rider_off` is low. Other bytes are ignored.
- LOCK: all bytes are ignored. After LOCK_CYCLES -> OFF with fail count cleared.
- `pwr_up` = 1 in PWR_LINK and PWR_GRACE only.

## Timing
- Outputs are flops loaded from next-state. The first cycle the state is PWR_LINK has `pwr_up = 1`, which is one clock after the `rx_rdy` cycle of the last matching PIN byte.
- Heartbeat counter width is $clog2(HB_TIMEOUT+1). It expires on the HB_TIMEOUT-th consecutive cycle without `rx_rdy`. It restarts on state entry into PIN or PWR_LINK.
- Simultaneous events:
  - `rx_rdy` in the expiry cycle: the byte is processed and the timeout is discarded.
  - STOP_BYTE and expiry together: handled once as STOP.
  - In PWR_GRACE, GO_BYTE in the same cycle the grace count completes: GO wins.
- Fail counter saturates at MAX_FAIL; no wrap.
- Reset asserted mid-operation returns everything to reset values immediately. `pwr_up` drops asynchronously.

## Configuration
- `AUTH_PIN_EN` defined: full behaviour as above.
- Undefined:
  - PIN and LOCK states, PIN compare logic and fail counter are not compiled.
  - GO_BYTE in OFF goes directly to PWR_LINK.
  - `locked` and `auth_fail` are tied 0.
  - PIN, PIN_LEN, MAX_FAIL and LOCK_CYCLES are unused.

## Structure
- Package `auth_pkg`:
  - `state_t` enum (OFF, PIN, PWR_LINK, PWR_GRACE, LOCK)
  - default GO/STOP byte localparams
- Sub-module: the existing `UART_rx` instance, providing `rx_data`, `rx_rdy` and `clr_rdy`. All FSM, timers and counters are local to `auth_ctrl`.

## Test plan
Parameter overrides for all scenarios: HB_TIMEOUT=1000, OFF_GRACE=200, LOCK_CYCLES=500, PIN=16'hA55A, MAX_FAIL=3.
- Send 67, A5, 5A -> `pwr_up` and `link_up` = 1 one cycle after the 5A `rx_rdy`. Then send 73 with `rider_off`=1 -> `pwr_up` = 0.
- Authenticate, then send 73 with `rider_off`=0 -> PWR_GRACE, `pwr_up` stays 1. Pulse `rider_off` for 150 cycles, then hold it -> `pwr_up` drops exactly 200 cycles after the final rise.
- Authenticate, go silent with `rider_off`=0 -> after 1000 cycles `link_up`=0, `pwr_up`=1. Send 67 -> `link_up`=1.
- Three attempts of 67, A5, 00 -> three `auth_fail` pulses, `locked`=1. Send 67, A5, 5A during lock -> ignored. `locked`=0 after 500 cycles, then a correct PIN powers up.
- Send 67, A5, then nothing for 1000 cycles -> back to OFF, no `auth_fail`. Assert rst_n while powered -> all outputs 0 in the same cycle.
- With `AUTH_PIN_EN` undefined: send 67 -> `pwr_up`=1 with no PIN. `locked` and `auth_fail` are never 1.
